// File: rtl/conv_out_requant.sv
// conv_out_requant: bias add, unsigned scale, rounding shift and ReLU/signed clamp
// on a stream of 32-bit accumulators, producing 8-bit pixels for a downstream FIFO.
// Writes are credit-limited against the FIFO occupancy; one row x col map per Start.
module conv_out_requant #(
    parameter int FIFO_DEPTH   = 1024,
    parameter int DCOUNT_WIDTH = 10
) (
    input  logic                    clk,
    input  logic                    srst,
    input  logic                    Start,
    input  logic [7:0]              output_layer_row_size,
    input  logic [7:0]              output_layer_col_size,
    input  logic signed [31:0]      bias,
    input  logic [15:0]             scale,
    input  logic [4:0]              shift,
    input  logic                    relu_en,
    input  logic signed [31:0]      acc_data,
    input  logic                    acc_valid,
    output logic                    acc_ready,
    output logic [7:0]              out_fifo_din,
    output logic                    out_fifo_wr_en,
    input  logic [DCOUNT_WIDTH-1:0] out_fifo_dcount,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t             state_q;
    logic [7:0]         row_size_q, col_size_q;
    logic signed [31:0] bias_q;
    logic [15:0]        scale_q;
    logic [4:0]         shift_q;
    logic               relu_q;
    logic [15:0]        total_q, acc_cnt_q, acc_cnt_d;
    logic [7:0]         row_cnt_q, col_cnt_q;
    logic               done_q;

    logic               vld_p0_q, vld_p1_q, wr_en_q;
    logic signed [32:0] sum_p0_q;
    logic signed [48:0] prod_p1_q;
    logic [7:0]         din_q;

    logic [1:0]              occ;
    logic [DCOUNT_WIDTH:0]   credit_use;
    logic                    hs;
    logic                    last_px;

    // Add half an LSB of the result (if any bits are shifted out), then arithmetic shift.
    function automatic logic signed [49:0] round_shift(input logic signed [48:0] p,
                                                       input logic [4:0] sh);
        logic signed [49:0] rnd;
        logic signed [49:0] t;
        rnd = (sh == 5'd0) ? 50'sd0 : (50'sd1 <<< (sh - 5'd1));
        t   = $signed({p[48], p}) + rnd;
        return t >>> sh;
    endfunction

    // ReLU clamps to 0..255; otherwise signed clamp to -128..127 in two's complement.
    function automatic logic [7:0] saturate(input logic signed [49:0] r, input logic relu);
        if (relu) begin
            if (r < 50'sd0)        return 8'h00;
            else if (r > 50'sd255) return 8'hFF;
            else                   return r[7:0];
        end else begin
            if (r < -50'sd128)     return 8'h80;
            else if (r > 50'sd127) return 8'h7F;
            else                   return r[7:0];
        end
    endfunction

    // Everything in flight counts against credit: dcount only reflects a write a cycle late.
    assign occ        = {1'b0, vld_p0_q} + {1'b0, vld_p1_q} + {1'b0, wr_en_q};
    assign credit_use = {1'b0, out_fifo_dcount} + {{(DCOUNT_WIDTH-1){1'b0}}, occ};
    assign acc_ready  = (state_q == RUN) && (acc_cnt_q < total_q) &&
                        (int'(credit_use) < FIFO_DEPTH);
    assign hs         = acc_valid && acc_ready;
    assign acc_cnt_d  = acc_cnt_q + 16'd1;
    assign last_px    = wr_en_q && (row_cnt_q == row_size_q - 8'd1) &&
                        (col_cnt_q == col_size_q - 8'd1);

    // Per-map configuration captured when a Start is accepted.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && Start) begin
            row_size_q <= output_layer_row_size;
            col_size_q <= output_layer_col_size;
            bias_q     <= bias;
            scale_q    <= scale;
            shift_q    <= shift;
            relu_q     <= relu_en;
            total_q    <= {8'd0, output_layer_row_size} * {8'd0, output_layer_col_size};
        end
    end

    // Control FSM with accept counter, pixel position counters and done pulse.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q   <= IDLE;
            acc_cnt_q <= '0;
            row_cnt_q <= '0;
            col_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (wr_en_q) begin
                if (col_cnt_q == col_size_q - 8'd1) begin
                    col_cnt_q <= '0;
                    row_cnt_q <= (row_cnt_q == row_size_q - 8'd1) ? 8'd0 : row_cnt_q + 8'd1;
                end else begin
                    col_cnt_q <= col_cnt_q + 8'd1;
                end
            end
            case (state_q)
                IDLE: begin
                    if (Start) begin
                        state_q   <= RUN;
                        acc_cnt_q <= '0;
                        row_cnt_q <= '0;
                        col_cnt_q <= '0;
                    end
                end
                RUN: begin
                    if (hs) begin
                        acc_cnt_q <= acc_cnt_d;
                        if (acc_cnt_d == total_q) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (last_px) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Valid bits and the output register; reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (srst) begin
            vld_p0_q <= 1'b0;
            vld_p1_q <= 1'b0;
            wr_en_q  <= 1'b0;
            din_q    <= 8'h00;
        end else begin
            vld_p0_q <= hs;
            vld_p1_q <= vld_p0_q;
            wr_en_q  <= vld_p1_q;
            if (vld_p1_q) din_q <= saturate(round_shift(prod_p1_q, shift_q), relu_q);
        end
    end

    // Arithmetic datapath: s1 bias add, s2 scale multiply (scale zero-extended).
    always_ff @(posedge clk) begin
        if (hs)       sum_p0_q  <= {acc_data[31], acc_data} + {bias_q[31], bias_q};
        if (vld_p0_q) prod_p1_q <= $signed({{16{sum_p0_q[32]}}, sum_p0_q}) *
                                   $signed({33'd0, scale_q});
    end

    assign out_fifo_din   = din_q;
    assign out_fifo_wr_en = wr_en_q;
    assign busy           = (state_q != IDLE);
    assign done           = done_q;

endmodule

// File: tb/tb_conv_out_requant.sv
// Testbench for conv_out_requant: scoreboard of expected pixels plus a FIFO occupancy model.
module tb_conv_out_requant;

    logic        clk = 1'b0;
    logic        srst = 1'b1;
    logic        Start = 1'b0;
    logic [7:0]  row_size = 8'd1;
    logic [7:0]  col_size = 8'd1;
    logic [31:0] bias = '0;
    logic [15:0] scale = '0;
    logic [4:0]  shift = '0;
    logic        relu_en = 1'b0;
    logic [31:0] acc_data = '0;
    logic        acc_valid = 1'b0;
    logic        acc_ready;
    logic [7:0]  out_fifo_din;
    logic        out_fifo_wr_en;
    logic [10:0] out_fifo_dcount;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    conv_out_requant #(.FIFO_DEPTH(1024), .DCOUNT_WIDTH(11)) dut (
        .clk                   (clk),
        .srst                  (srst),
        .Start                 (Start),
        .output_layer_row_size (row_size),
        .output_layer_col_size (col_size),
        .bias                  (bias),
        .scale                 (scale),
        .shift                 (shift),
        .relu_en               (relu_en),
        .acc_data              (acc_data),
        .acc_valid             (acc_valid),
        .acc_ready             (acc_ready),
        .out_fifo_din          (out_fifo_din),
        .out_fifo_wr_en        (out_fifo_wr_en),
        .out_fifo_dcount       (out_fifo_dcount),
        .busy                  (busy),
        .done                  (done)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  exp_q[$];
    int          n_hs = 0;
    int          n_wr = 0;
    int          done_cnt = 0;
    longint      first_wr_t = -1;
    longint      last_wr_t = 0;
    longint      done_t = 0;
    longint      first_hs_t = -1;
    int          fifo_cnt = 0;
    int          rd_mode = 0;
    bit          load_req = 1'b0;
    int          load_val = 0;
    int          max_tot = 0;

    assign out_fifo_dcount = 11'(fifo_cnt);

    // FIFO occupancy model: a write lands one edge after wr_en, reads as rd_mode dictates
    always @(posedge clk) begin
        bit rd;
        if (load_req) begin
            fifo_cnt <= load_val;
        end else begin
            rd = (rd_mode == 1) || (rd_mode == 2 && $urandom_range(1, 0) == 1);
            fifo_cnt <= fifo_cnt + (out_fifo_wr_en ? 1 : 0) - ((rd && fifo_cnt > 0) ? 1 : 0);
        end
    end

    // Scoreboard: pop and compare every written pixel; track FIFO-plus-in-flight peak
    always @(negedge clk) begin
        logic [7:0] e;
        if (fifo_cnt + n_hs - n_wr > max_tot) max_tot = fifo_cnt + n_hs - n_wr;
        if (out_fifo_wr_en) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write: got din=%0d with no pending pixel, want no write", out_fifo_din);
            end else begin
                e = exp_q.pop_front();
                if (out_fifo_din !== e) begin
                    n_bad++;
                    $display("FAIL pixel[%0d]: got 0x%02h, want 0x%02h", n_wr, out_fifo_din, e);
                end
            end
            n_wr++;
            if (first_wr_t < 0) first_wr_t = $time;
            last_wr_t = $time;
        end
        if (done) begin
            done_cnt++;
            done_t = $time;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] model(input logic [31:0] a);
        longint s, p, r;
        s = longint'($signed(a)) + longint'($signed(bias));
        p = s * longint'(scale);
        if (shift != 5'd0) p = p + (longint'(1) << (shift - 5'd1));
        r = p >>> shift;
        if (relu_en) begin
            if (r < 0) return 8'h00;
            if (r > 255) return 8'hFF;
            return r[7:0];
        end
        if (r < -128) return 8'h80;
        if (r > 127) return 8'h7F;
        return r[7:0];
    endfunction

    task automatic send(input logic [31:0] a, input logic [7:0] e);
        int g;
        g = 0;
        acc_data  = a;
        acc_valid = 1'b1;
        while (1) begin
            @(posedge clk);
            if (acc_ready) begin
                exp_q.push_back(e);
                n_hs++;
                if (first_hs_t < 0) first_hs_t = $time;
                break;
            end
            g++;
            if (g > 4000) begin
                n_cmp++; n_bad++;
                $display("FAIL send_timeout: acc_ready low for %0d cycles, want handshake", g);
                break;
            end
        end
        @(negedge clk);
        acc_valid = 1'b0;
    endtask

    task automatic start_map(input int r, input int c, input logic [31:0] b,
                             input logic [15:0] sc, input logic [4:0] sh, input logic re);
        @(negedge clk);
        row_size = 8'(r); col_size = 8'(c);
        bias = b; scale = sc; shift = sh; relu_en = re;
        first_wr_t = -1; first_hs_t = -1;
        Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
    endtask

    task automatic wait_done(output bit ok, input int budget);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1'b1; break; end
        end
        #1;
    endtask

    task automatic test_reset;
        srst = 1'b1; acc_valid = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (acc_ready !== 1'b0) begin n_bad++; $display("FAIL reset_acc_ready: got %0b, want 0", acc_ready); end
        n_cmp++; if (out_fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en: got %0b, want 0", out_fifo_wr_en); end
        n_cmp++; if (out_fifo_din !== 8'h00) begin n_bad++; $display("FAIL reset_din: got 0x%02h, want 0x00", out_fifo_din); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0b, want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %0b, want 0", done); end
        srst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (acc_ready !== 1'b0) begin n_bad++; $display("FAIL idle_acc_ready: got %0b, want 0", acc_ready); end
        n_cmp++; if (out_fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL idle_wr_en: got %0b, want 0", out_fifo_wr_en); end
        acc_valid = 1'b0;
    endtask

    task automatic test_basic;
        int w0, d0; bit ok;
        rd_mode = 1;
        start_map(2, 2, -32'sd200, 16'd1, 5'd2, 1'b1);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy: got %0b, want 1", busy); end
        w0 = n_wr; d0 = done_cnt;
        send(32'd1000, 8'd200);
        send(32'd400, 8'd50);
        send(-32'sd50, 8'd0);
        send(32'd100000, 8'd255);
        wait_done(ok, 50);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL basic_done_timeout: busy stayed high, want done"); end
        n_cmp++; if (n_wr - w0 != 4) begin n_bad++; $display("FAIL basic_writes: got %0d, want 4", n_wr - w0); end
        n_cmp++; if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL basic_done_count: got %0d, want 1", done_cnt - d0); end
        n_cmp++; if (done_t != last_wr_t + 10) begin n_bad++; $display("FAIL basic_done_timing: got t=%0d, want t=%0d", done_t, last_wr_t + 10); end
        n_cmp++; if (first_wr_t - first_hs_t != 25) begin n_bad++; $display("FAIL basic_latency: got %0d, want 25", first_wr_t - first_hs_t); end
    endtask

    task automatic test_round;
        int w0; bit ok;
        start_map(2, 2, 32'd0, 16'd3, 5'd1, 1'b0);
        w0 = n_wr;
        send(32'd1, 8'h02);
        send(-32'sd1, 8'hFF);
        send(32'd100, 8'h7F);
        send(-32'sd100, 8'h80);
        wait_done(ok, 50);
        n_cmp++; if (!ok || n_wr - w0 != 4) begin n_bad++; $display("FAIL round_writes: got %0d ok=%0b, want 4 ok=1", n_wr - w0, ok); end
    endtask

    task automatic test_one(input int tag);
        int w0, d0; bit ok;
        start_map(1, 1, 32'd5, 16'd2, 5'd0, 1'b1);
        w0 = n_wr; d0 = done_cnt;
        send(32'd10, 8'd30);
        wait_done(ok, 50);
        n_cmp++; if (!ok || n_wr - w0 != 1) begin n_bad++; $display("FAIL one_writes[%0d]: got %0d ok=%0b, want 1 ok=1", tag, n_wr - w0, ok); end
        n_cmp++; if (done_cnt - d0 != 1 || done_t != last_wr_t + 10) begin n_bad++; $display("FAIL one_done[%0d]: got count=%0d t=%0d, want 1 at t=%0d", tag, done_cnt - d0, done_t, last_wr_t + 10); end
    endtask

    task automatic test_latency;
        int w0, d0; bit ok; logic [31:0] a;
        rd_mode = 1;
        start_map(55, 55, $urandom_range(4000, 0) - 2000, 16'($urandom), 5'($urandom_range(20, 8)), 1'($urandom));
        w0 = n_wr; d0 = done_cnt;
        for (int i = 0; i < 3025; i++) begin
            a = $urandom;
            send(a, model(a));
        end
        wait_done(ok, 100);
        n_cmp++; if (!ok || n_wr - w0 != 3025) begin n_bad++; $display("FAIL lat_writes: got %0d ok=%0b, want 3025 ok=1", n_wr - w0, ok); end
        n_cmp++; if (first_wr_t - first_hs_t != 25) begin n_bad++; $display("FAIL lat_first: got %0d, want 25", first_wr_t - first_hs_t); end
        n_cmp++; if (last_wr_t - first_wr_t != 30240) begin n_bad++; $display("FAIL lat_back_to_back: got span %0d, want 30240", last_wr_t - first_wr_t); end
        n_cmp++; if (done_cnt - d0 != 1 || done_t != last_wr_t + 10) begin n_bad++; $display("FAIL lat_done: got count=%0d t=%0d, want 1 at t=%0d", done_cnt - d0, done_t, last_wr_t + 10); end
    endtask

    task automatic test_credit;
        int w0, k; bit ok; logic [31:0] a;
        rd_mode = 0;
        @(negedge clk); load_val = 1021; load_req = 1'b1;
        @(negedge clk); load_req = 1'b0;
        max_tot = 0;
        start_map(4, 4, 32'd0, 16'd1, 5'd0, 1'b1);
        w0 = n_wr; k = 0;
        for (int i = 0; i < 20; i++) begin
            a = $urandom_range(300, 0);
            acc_data = a; acc_valid = 1'b1;
            @(posedge clk);
            if (acc_ready) begin exp_q.push_back(model(a)); n_hs++; k++; end
            @(negedge clk);
        end
        acc_valid = 1'b0;
        n_cmp++; if (k != 3) begin n_bad++; $display("FAIL credit_handshakes: got %0d, want 3", k); end
        rd_mode = 2;
        for (int i = 0; i < 13; i++) begin
            a = $urandom_range(300, 0);
            send(a, model(a));
        end
        wait_done(ok, 500);
        n_cmp++; if (!ok || n_wr - w0 != 16) begin n_bad++; $display("FAIL credit_writes: got %0d ok=%0b, want 16 ok=1", n_wr - w0, ok); end
        n_cmp++; if (max_tot > 1024) begin n_bad++; $display("FAIL credit_overflow: got peak %0d, want <= 1024", max_tot); end
        rd_mode = 1;
    endtask

    task automatic test_random;
        int w0, d0; bit ok; logic [31:0] a;
        @(negedge clk); load_val = 1010; load_req = 1'b1;
        @(negedge clk); load_req = 1'b0;
        rd_mode = 2; max_tot = 0;
        start_map(12, 10, $urandom, 16'($urandom), 5'($urandom), 1'($urandom));
        w0 = n_wr; d0 = done_cnt;
        for (int i = 0; i < 120; i++) begin
            repeat ($urandom_range(2, 0)) @(negedge clk);
            a = $urandom;
            send(a, model(a));
        end
        wait_done(ok, 500);
        n_cmp++; if (!ok || n_wr - w0 != 120) begin n_bad++; $display("FAIL rand_writes: got %0d ok=%0b, want 120 ok=1", n_wr - w0, ok); end
        n_cmp++; if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL rand_done: got %0d, want 1", done_cnt - d0); end
        n_cmp++; if (max_tot > 1024) begin n_bad++; $display("FAIL rand_overflow: got peak %0d, want <= 1024", max_tot); end
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL rand_pending: got %0d left, want 0", exp_q.size()); end
        rd_mode = 1;
    endtask

    task automatic test_start_ignored;
        int w0, d0; bit ok; logic [31:0] a;
        rd_mode = 1;
        start_map(3, 3, 32'd7, 16'd5, 5'd3, 1'b0);
        w0 = n_wr; d0 = done_cnt;
        for (int i = 0; i < 4; i++) begin a = $urandom_range(60, 0) - 30; send(a, model(a)); end
        row_size = 8'd7; col_size = 8'd7; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL restart_busy: got %0b, want 1", busy); end
        for (int i = 0; i < 5; i++) begin a = $urandom_range(60, 0) - 30; send(a, model(a)); end
        wait_done(ok, 50);
        n_cmp++; if (!ok || n_wr - w0 != 9) begin n_bad++; $display("FAIL restart_writes: got %0d ok=%0b, want 9 ok=1", n_wr - w0, ok); end
        n_cmp++; if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL restart_done: got %0d, want 1", done_cnt - d0); end
        w0 = n_wr; acc_valid = 1'b1;
        repeat (6) @(negedge clk);
        acc_valid = 1'b0;
        n_cmp++; if (n_wr != w0 || acc_ready !== 1'b0) begin n_bad++; $display("FAIL idle_ignore: got %0d writes ready=%0b, want 0 writes ready=0", n_wr - w0, acc_ready); end
    endtask

    task automatic test_reset_mid;
        int w0; logic [31:0] a;
        rd_mode = 1;
        start_map(20, 20, $urandom_range(1000, 0), 16'd9, 5'd4, 1'b1);
        w0 = n_wr;
        while (n_wr - w0 < 100) begin
            a = $urandom_range(2000, 0) - 1000;
            send(a, model(a));
        end
        srst = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (out_fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL midreset_wr_en: got %0b, want 0", out_fifo_wr_en); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midreset_busy: got %0b, want 0", busy); end
        n_cmp++; if (acc_ready !== 1'b0) begin n_bad++; $display("FAIL midreset_acc_ready: got %0b, want 0", acc_ready); end
        exp_q.delete();
        n_hs = n_wr;
        @(negedge clk);
        srst = 1'b0;
        w0 = n_wr;
        repeat (5) @(negedge clk);
        n_cmp++; if (n_wr != w0) begin n_bad++; $display("FAIL midreset_stray_writes: got %0d, want 0", n_wr - w0); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_round;
        test_one(0);
        test_latency;
        test_credit;
        test_random;
        test_start_ignored;
        test_reset_mid;
        test_one(1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
